// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer: walks a shared-ALU/shared-memory datapath through FETCH/DECODE/EXEC/MEM/WB.
// Control outputs decode from the state register; memory waits are counted and a hung access traps in FAULT.
module multicycle_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcEn,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       pcSrc,
  output logic       instrDone,
  output logic       illegal,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_FAULT  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               TIMEOUT_EN  = (WAIT_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             in_mem;
  logic             mem_stall;
  logic             timeout_hit;

  assign in_mem      = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_stall   = in_mem && !memReady;
  // A ready response on the timeout cycle still completes the access normally.
  assign timeout_hit = TIMEOUT_EN && mem_stall && (wait_cnt_q == TIMEOUT_VAL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (memReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_FAULT;
  end

  // Every path into a memory state leaves with memReady=1 or via FAULT, so the
  // count is already zero on entry; it only grows while a memory state stalls.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Reset gates every output so an in-flight memory request drops immediately.
  always_comb begin
    pcEn      = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    pcSrc     = 1'b0;
    instrDone = 1'b0;
    illegal   = 1'b0;
    fault     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = memReady;
          pcEn    = memReady;
        end
        S_DECODE: begin
          aluSrcB = 2'b11;
          illegal = !((opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_ADDI));
        end
        S_MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        S_MEMRD: begin
          iorD    = 1'b1;
          memRead = 1'b1;
        end
        S_MEMWB: begin
          memToReg  = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_MEMWR: begin
          iorD      = 1'b1;
          memWrite  = 1'b1;
          instrDone = memReady;
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          aluOp   = 2'b10;
        end
        S_ALUWB: begin
          regDst    = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA   = 1'b1;
          aluOp     = 2'b01;
          pcSrc     = 1'b1;
          pcEn      = zero;
          instrDone = 1'b1;
        end
        S_ADDIEX: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        S_ADDIWB: begin
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_FAULT:  fault = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule
